// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the two-requester shift arbiter.
// DATA_W/SHAMT_W size the operand and shift amount; the state enum is 2 bits wide.
package shift_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Logarithmic logical barrel shifter with zero fill.
// direction = 1 shifts left, direction = 0 shifts right.
module barrel_shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] shift,
  input  logic               direction,
  output logic [DATA_W-1:0]  out
);

  logic [DATA_W-1:0] stage;

  // Each stage handles one bit of the shift amount: 1, 2, then 4 positions.
  always_comb begin
    stage = in;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (shift[i]) begin
        stage = direction ? (stage << (1 << i)) : (stage >> (1 << i));
      end
    end
    out = stage;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a shared
// barrel shifter; each operation walks IDLE -> SHIFT -> RESP.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [DATA_W-1:0]    req_in0,
  input  logic [DATA_W-1:0]    req_in1,
  input  logic [SHAMT_W-1:0]   req_shift0,
  input  logic [SHAMT_W-1:0]   req_shift1,
  input  logic                 req_dir0,
  input  logic                 req_dir1,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: a request transfers in the cycle req_valid[i] and req_ready[i]
  // are both high (req_ready only ever rises in IDLE); a response transfers in
  // the cycle rsp_valid[i] and rsp_ready[i] are both high. Requesters hold
  // their fields stable while req_valid is up and not yet accepted.

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [SHAMT_W-1:0]  shamt_q, shamt_d;
  logic                dir_q, dir_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                any_req;
  logic                grant_id;
  logic [DATA_W-1:0]   shift_out;

  assign any_req  = |req_valid;
  // A lone requester wins outright; the pointer only breaks ties.
  assign grant_id = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  barrel_shifter u_shifter (
    .in        (op_q),
    .shift     (shamt_q),
    .direction (dir_q),
    .out       (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      op_q    <= '0;
      shamt_q <= '0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready[id_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    dir_d   = dir_q;
    id_d    = id_q;
    data_d  = data_q;
    if (state_q == ST_IDLE && any_req) begin
      id_d  = grant_id;
      ptr_d = ~ptr_q;
      if (grant_id) begin
        op_d    = req_in1;
        shamt_d = req_shift1;
        dir_d   = req_dir1;
      end else begin
        op_d    = req_in0;
        shamt_d = req_shift0;
        dir_d   = req_dir0;
      end
    end
    if (state_q == ST_SHIFT) begin
      data_d = shift_out;
    end
  end

  // req_ready is gated by rst_n so it drops the instant reset asserts,
  // even while a requester is still holding req_valid.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == ST_IDLE && any_req && rst_n) begin
      req_ready = id_to_onehot(grant_id);
    end
    if (state_q == ST_RESP) begin
      rsp_valid = id_to_onehot(id_q);
    end
  end

  assign rsp_data    = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have parameters: none; width fixed at 8 data bits and 3 shift bits.
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have the ports req_valid, input, 2 bits: per-requester request valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 The module SHALL have the ports req_ready, output, 2 bits: per-requester request accepted this cycle.
REQ-006 The module SHALL have the ports req_in0 and req_in1, input, 8 bits each: the operand from requesters 0 and 1.
REQ-007 The module SHALL have the ports req_shift0 and req_shift1, input, 3 bits each: the shift amount, 0-7.
REQ-008 The module SHALL have the ports req_dir0 and req_dir1, input, 1 bit each: 1 = shift left, 0 = shift right.
REQ-009 The module SHALL have the port rsp_valid, output, 2 bits: the result is valid for the indicated requester.
REQ-010 The module SHALL have the port rsp_ready, input, 2 bits: the requester accepts the result.
REQ-011 The module SHALL have the port rsp_data, output, 8 bits: the result, shared by both requesters.
REQ-012 The module SHALL have the port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and RESP, encoded in 2 bits.
REQ-014 In IDLE with any req_valid bit set, the FSM SHALL grant exactly one requester, pulse its req_ready for one cycle, and latch its operand, shift amount, direction and grant ID, then go to SHIFT.
REQ-015 Arbitration SHALL be round-robin: a priority pointer points at the requester that wins a tie, and on every grant the pointer moves to the other requester.
REQ-016 The reset value of the priority pointer SHALL be 0.
REQ-017 A single requester asserting req_valid SHALL be granted regardless of the pointer.
REQ-018 req_ready SHALL be asserted only in IDLE.
REQ-019 In SHIFT, the latched fields SHALL drive the barrel shifter, and its output SHALL be registered into rsp_data; the FSM then goes to RESP.
REQ-020 In RESP, the FSM SHALL assert rsp_valid only on the bit of the granted ID and hold rsp_data stable.
REQ-021 When rsp_ready is set on the granted bit in RESP, the FSM SHALL go to IDLE; otherwise it SHALL stay in RESP indefinitely.
REQ-022 rsp_ready on the bit of the non-granted requester SHALL be ignored.
REQ-023 Shift semantics SHALL be logical with zero fill. A shift amount of 0 SHALL pass the operand unchanged.
REQ-024 Latency from the req_ready pulse to the first cycle of rsp_valid SHALL be 2 cycles.
REQ-025 Maximum throughput SHALL be one operation per 3 cycles.
REQ-026 A request arriving while busy SHALL wait with req_valid held; the requester keeps its fields stable until it sees req_ready.

Reset
REQ-027 Assertion of rst_n low SHALL immediately, without waiting for a clock edge, force: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=8'h00, busy=0, pointer=0, latched fields=0.
REQ-028 Reset during SHIFT or RESP SHALL abort the operation; no response is delivered after reset is released.
REQ-029 Deassertion of rst_n SHALL take effect at the next rising edge of clk; the first grant occurs no earlier than that edge.

Structure
REQ-030 The state encodings and the width constants (DATA_W=8, SHAMT_W=3) SHALL be defined in a shared package, shift_pkg.
REQ-031 The module SHALL instantiate exactly one existing barrel_shifter (ports in, shift, direction, out) as its only sub-module.
REQ-032 All other logic (FSM, arbiter, latches) SHALL be flat in shift_arbiter.

Verification
REQ-033 Scenario, single left shift: req_valid=01, in0=8'hF0, shift0=2, dir0=1 -> req_ready=01 for one cycle; 2 cycles later rsp_valid=01 and rsp_data=8'hC0.
REQ-034 Scenario, single right shift: req_valid=10, in1=8'hF0, shift1=2, dir1=0 -> rsp_valid=10, rsp_data=8'h3C.
REQ-035 Scenario, tie after reset: req_valid=11 held, rsp_ready=11 held -> grants go 0,1,0,1 and the results alternate to the matching rsp_valid bit.
REQ-036 Scenario, response backpressure: rsp_ready=00 for 5 cycles in RESP -> rsp_valid and rsp_data are held; req_ready stays 00; with rsp_ready=01 the FSM returns to IDLE.
REQ-037 Scenario, mid-operation reset: rst_n=0 in SHIFT -> rsp_valid=00, rsp_data=8'h00 and busy=0 asynchronously; after release, req_valid=11 is granted to requester 0.
REQ-038 Scenario, shift amount 0 and 7: in=8'h81 with shift 0 -> 8'h81; shift 7 left -> 8'h80; shift 7 right -> 8'h01.
